// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: bit-serial adder sequencer built around one shared FullAdder.
// One result bit is produced per clock, so a WIDTH-bit add takes WIDTH cycles in RUN
// followed by a single DONE cycle that pulses done.
// Optional feature macro: SERIAL_ADD_SUB_EN adds a 'sub' input that turns the
// operation into a - b by loading ~b and presetting the carry flip-flop to 1.

module FullAdder (
  input  logic i_a,
  input  logic i_b,
  input  logic i_c,
  output logic o_sum,
  output logic o_carry
);

  assign o_sum   = i_a ^ i_b ^ i_c;
  assign o_carry = (i_a & i_b) | (i_c & (i_a ^ i_b));

endmodule

module serial_add_ctrl #(
  parameter int WIDTH = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
`ifdef SERIAL_ADD_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             r_state;
  logic [WIDTH-1:0]   r_sa;
  logic [WIDTH-1:0]   r_sb;
  logic [WIDTH-1:0]   r_sum;
  logic               r_carry;
  logic [CNT_W-1:0]   r_count;
  logic               r_busy;
  logic               r_done;

  logic               w_faSum;
  logic               w_faCarry;
  logic               w_accept;
  logic               w_lastBit;
  logic [WIDTH-1:0]   w_loadB;
  logic               w_loadCarry;

  // The single adder cell that every bit position shares over time.
  FullAdder u_fullAdder (
    .i_a    (r_sa[0]),
    .i_b    (r_sb[0]),
    .i_c    (r_carry),
    .o_sum  (w_faSum),
    .o_carry(w_faCarry)
  );

  // A new request is only honoured when no add is in flight.
  assign w_accept  = start && ((r_state == IDLE) || (r_state == DONE));
  assign w_lastBit = (r_count == CNT_W'(WIDTH - 1));

`ifdef SERIAL_ADD_SUB_EN
  // Subtraction is a + ~b + 1, so the +1 rides in on the preset carry.
  assign w_loadB     = sub ? ~b : b;
  assign w_loadCarry = sub;
`else
  assign w_loadB     = b;
  assign w_loadCarry = 1'b0;
`endif

  // Sequencer: loads operands, shifts one bit per clock through the adder, then pulses done.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= IDLE;
      r_sa    <= '0;
      r_sb    <= '0;
      r_sum   <= '0;
      r_carry <= 1'b0;
      r_count <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        IDLE, DONE: begin
          r_done <= 1'b0;
          if (w_accept) begin
            r_sa    <= a;
            r_sb    <= w_loadB;
            r_carry <= w_loadCarry;
            r_count <= '0;
            r_busy  <= 1'b1;
            r_state <= RUN;
          end else begin
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end
        end
        RUN: begin
          r_sa    <= r_sa >> 1;
          r_sb    <= r_sb >> 1;
          r_sum   <= {w_faSum, r_sum[WIDTH-1:1]};
          r_carry <= w_faCarry;
          r_count <= r_count + CNT_W'(1);
          if (w_lastBit) begin
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= DONE;
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign busy      = r_busy;
  assign done      = r_done;
  assign sum       = r_sum;
  assign carry_out = r_carry;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// tb_serial_add_ctrl: randomized scoreboard bench for serial_add_ctrl (WIDTH=16).
// Build with SERIAL_ADD_SUB_EN defined to also exercise the subtract mode.

module tb_serial_add_ctrl;

  localparam int W = 16;

  logic         clock;
  logic         reset;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
`ifdef SERIAL_ADD_SUB_EN
  logic         sub;
`endif
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         carry_out;

  typedef struct {
    logic [W-1:0] expSum;
    logic         expCarry;
    int           doneEdge;
  } expect_t;

  expect_t      scoreQ[$];
  int           edgeCount = 0;
  int           checkCount = 0;
  int           errorCount = 0;
  bit           monitorOn = 0;
  logic [W-1:0] lastSum = '0;
  logic         lastCarry = 1'b0;

  serial_add_ctrl #(.WIDTH(W)) dut (
    .clock    (clock),
    .reset    (reset),
    .start    (start),
    .a        (a),
    .b        (b),
`ifdef SERIAL_ADD_SUB_EN
    .sub      (sub),
`endif
    .busy     (busy),
    .done     (done),
    .sum      (sum),
    .carry_out(carry_out)
  );

  // Free-running clock.
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Rising-edge counter used to timestamp expected done pulses.
  always @(posedge clock) edgeCount <= edgeCount + 1;

  // Reference model: plain unsigned arithmetic on the operands.
  function automatic expect_t refModel(input logic [W-1:0] av, input logic [W-1:0] bv,
                                       input logic subv, input int doneEdge);
    expect_t e;
    int unsigned total;
    if (subv) begin
      e.expSum   = av - bv;
      e.expCarry = (av >= bv);
    end else begin
      total      = int'(av) + int'(bv);
      e.expSum   = W'(total);
      e.expCarry = (total >= (1 << W));
    end
    e.doneEdge = doneEdge;
    return e;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0h expected %0h (edge %0d)", name, actual, expected, edgeCount);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Issue one operation; glitchAt>0 pulses a stray start during that RUN cycle.
  task automatic applyStimulus(input logic [W-1:0] av, input logic [W-1:0] bv,
                               input logic subv, input int glitchAt, input int idleAfter);
    start = 1'b1;
    a     = av;
    b     = bv;
`ifdef SERIAL_ADD_SUB_EN
    sub   = subv;
`endif
    scoreQ.push_back(refModel(av, bv, subv, edgeCount + 1 + W));
    tick();
    start = 1'b0;
    a     = W'($urandom);
    b     = W'($urandom);
    for (int i = 1; i <= W; i++) begin
      if (i == glitchAt) begin
        start = 1'b1;
        a     = 16'h1111;
        b     = 16'h1111;
      end else begin
        start = 1'b0;
      end
      tick();
    end
    start = 1'b0;
    repeat (idleAfter) tick();
  endtask

  // Two operations with start held high so the second is taken in the DONE cycle.
  task automatic applyBackToBack(input logic [W-1:0] a1, input logic [W-1:0] b1,
                                 input logic [W-1:0] a2, input logic [W-1:0] b2,
                                 input logic subv);
    int firstDone;
    start = 1'b1;
    a     = a1;
    b     = b1;
`ifdef SERIAL_ADD_SUB_EN
    sub   = subv;
`endif
    firstDone = edgeCount + 1 + W;
    scoreQ.push_back(refModel(a1, b1, subv, firstDone));
    scoreQ.push_back(refModel(a2, b2, subv, firstDone + 1 + W));
    tick();
    a = a2;
    b = b2;
    repeat (W) tick();
    tick();
    start = 1'b0;
    repeat (W) tick();
    tick();
  endtask

  // Monitor: compares DUT outputs against the scoreboard on every falling edge.
  always @(negedge clock) begin
    if (monitorOn) begin
      if (scoreQ.size() > 0 && edgeCount == scoreQ[0].doneEdge) begin
        checkOutput("donePulse", 64'(done), 64'(1'b1));
        checkOutput("busyInDone", 64'(busy), 64'(1'b0));
        checkOutput("sumResult", 64'(sum), 64'(scoreQ[0].expSum));
        checkOutput("carryResult", 64'(carry_out), 64'(scoreQ[0].expCarry));
        lastSum   = scoreQ[0].expSum;
        lastCarry = scoreQ[0].expCarry;
        void'(scoreQ.pop_front());
      end else begin
        automatic bit inRun = (scoreQ.size() > 0) && (edgeCount >= scoreQ[0].doneEdge - W);
        checkOutput("noDone", 64'(done), 64'(1'b0));
        checkOutput("busyFlag", 64'(busy), 64'(inRun));
        if (!inRun) begin
          checkOutput("sumHold", 64'(sum), 64'(lastSum));
          checkOutput("carryHold", 64'(carry_out), 64'(lastCarry));
        end
      end
    end
  end

  // Watchdog so the run can never hang.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Stimulus sequence.
  initial begin
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    logic         rs;
    reset = 1'b1;
    start = 1'b0;
    a     = '0;
    b     = '0;
`ifdef SERIAL_ADD_SUB_EN
    sub   = 1'b0;
`endif
    tick();
    tick();
    reset = 1'b0;
    checkOutput("resetBusy", 64'(busy), 64'(1'b0));
    checkOutput("resetDone", 64'(done), 64'(1'b0));
    checkOutput("resetSum", 64'(sum), 64'(0));
    checkOutput("resetCarry", 64'(carry_out), 64'(1'b0));
    monitorOn = 1;
    tick();

    applyStimulus(16'h0003, 16'h0005, 1'b0, 0, 2);
    applyStimulus(16'hFFFF, 16'h0001, 1'b0, 0, 5);
    applyStimulus(16'h1234, 16'h4321, 1'b0, 5, 2);

    // Abort an add part-way through with reset.
    start = 1'b1;
    a     = 16'h00FF;
    b     = 16'h0001;
`ifdef SERIAL_ADD_SUB_EN
    sub   = 1'b0;
`endif
    scoreQ.push_back(refModel(16'h00FF, 16'h0001, 1'b0, edgeCount + 1 + W));
    tick();
    start = 1'b0;
    repeat (8) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    scoreQ.delete();
    lastSum   = '0;
    lastCarry = 1'b0;
    checkOutput("abortBusy", 64'(busy), 64'(1'b0));
    checkOutput("abortDone", 64'(done), 64'(1'b0));
    checkOutput("abortSum", 64'(sum), 64'(0));
    checkOutput("abortCarry", 64'(carry_out), 64'(1'b0));
    repeat (W + 4) tick();

    applyBackToBack(16'h7FFF, 16'h0001, 16'h8000, 16'h8000, 1'b0);
    repeat (3) tick();

    // Reset and start together: reset wins.
    applyStimulus(16'hABCD, 16'h1357, 1'b0, 0, 1);
    reset = 1'b1;
    start = 1'b1;
    a     = 16'h2222;
    b     = 16'h3333;
    tick();
    reset = 1'b0;
    start = 1'b0;
    lastSum   = '0;
    lastCarry = 1'b0;
    checkOutput("resetStartBusy", 64'(busy), 64'(1'b0));
    repeat (3) tick();

`ifdef SERIAL_ADD_SUB_EN
    applyStimulus(16'h0005, 16'h0003, 1'b1, 0, 1);
    applyStimulus(16'h0003, 16'h0005, 1'b1, 0, 1);
    applyStimulus(16'h0007, 16'h0007, 1'b1, 0, 1);
`endif

    for (int n = 0; n < 24; n++) begin
      ra = W'($urandom);
      rb = W'($urandom);
`ifdef SERIAL_ADD_SUB_EN
      rs = 1'($urandom_range(0, 1));
`else
      rs = 1'b0;
`endif
      if ($urandom_range(0, 3) == 0) begin
        applyBackToBack(ra, rb, W'($urandom), W'($urandom), rs);
      end else begin
        applyStimulus(ra, rb, rs, (n % 3 == 0) ? int'($urandom_range(1, W - 1)) : 0,
                      int'($urandom_range(0, 3)));
      end
    end

    repeat (4) tick();
    checkOutput("pendingResults", 64'(scoreQ.size()), 64'(0));
    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
